// File: rtl/mdu_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
interface mdu_if;
   logic [3:0]  mdu_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rd_data;

   modport master (
      output mdu_op, rs_val, rt_val,
      input  start, busy, hi, lo, rd_data
   );

   modport slave (
      input  mdu_op, rs_val, rt_val,
      output start, busy, hi, lo, rd_data
   );
endinterface

// File: rtl/mdu.sv
// Multi-cycle mult/div unit with HI/LO registers and fixed latency.
// Optional MADD (opcode 9) is enabled by defining MDU_MADD_EN.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic  clk,
   input logic  reset,
   mdu_if.slave bus
);
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] tmp_hi_q, tmp_hi_d;
   logic [31:0] tmp_lo_q, tmp_lo_d;

   logic [31:0] rs, rt, dvs;
   logic [31:0] abs_rs, abs_rt;
   logic [31:0] uq, ur, sq, sr;
   logic [63:0] prod_s, prod_u, res;
   logic        is_mul, is_div, start;

   assign rs = bus.rs_val;
   assign rt = bus.rt_val;

   // Sign-extended 64x64 product keeps the low 64 bits of the signed result.
   assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
   assign prod_u = {32'd0, rs} * {32'd0, rt};

   assign abs_rs = rs[31] ? -rs : rs;
   assign abs_rt = rt[31] ? -rt : rt;
   assign dvs    = (rt == 32'd0) ? 32'd1 : rt;
   assign uq     = abs_rs / ((abs_rt == 32'd0) ? 32'd1 : abs_rt);
   assign ur     = abs_rs % ((abs_rt == 32'd0) ? 32'd1 : abs_rt);
   // Overflow 0x8000_0000 / -1 falls out naturally as lo=0x8000_0000, hi=0.
   assign sq     = (rs[31] ^ rt[31]) ? -uq : uq;
   assign sr     = rs[31] ? -ur : ur;

`ifdef MDU_MADD_EN
   assign is_mul = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU) ||
                   (bus.mdu_op == OP_MADD);
`else
   assign is_mul = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU);
`endif
   assign is_div = (bus.mdu_op == OP_DIV) || (bus.mdu_op == OP_DIVU);
   assign start  = (is_mul || is_div) && (state_q == IDLE);

   always_comb begin
      res = {hi_q, lo_q};
      case (bus.mdu_op)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV:   if (rt != 32'd0) res = {sr, sq};
         OP_DIVU:  if (rt != 32'd0) res = {rs % dvs, rs / dvs};
`ifdef MDU_MADD_EN
         OP_MADD:  res = {hi_q, lo_q} + prod_s;
`endif
         default:  res = {hi_q, lo_q};
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      tmp_hi_d = tmp_hi_q;
      tmp_lo_d = tmp_lo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               {tmp_hi_d, tmp_lo_d} = res;
               cnt_d   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
               state_d = RUN;
            end else if (bus.mdu_op == OP_MTHI) begin
               hi_d = rs;
            end else if (bus.mdu_op == OP_MTLO) begin
               lo_d = rs;
            end
         end
         RUN: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               hi_d    = tmp_hi_q;
               lo_d    = tmp_lo_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         tmp_hi_q <= 32'd0;
         tmp_lo_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         tmp_hi_q <= tmp_hi_d;
         tmp_lo_q <= tmp_lo_d;
      end
   end

   assign bus.start   = start;
   assign bus.busy    = (state_q == RUN);
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.rd_data = (bus.mdu_op == OP_MFHI) ? hi_q :
                        (bus.mdu_op == OP_MFLO) ? lo_q : 32'd0;
endmodule
